// File: rtl/gate_exhaustive_tester.sv
// Exhaustive stimulus engine for an N_IN-input gate: sweeps every input vector, compares the
// gate output against a golden reduction, and reports mismatch count, first failing vector and pass.
module gate_exhaustive_tester #(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 2,
    parameter int ERR_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic              dut_out,
    output logic [N_IN-1:0]   stim,
    output logic              expected,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_valid
);

    // state  | meaning
    // S_IDLE | waiting for the first start after reset
    // S_RUN  | sweeping vectors, one sample per HOLD_CYCLES
    // S_DONE | sweep finished, results held until the next start
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [2:0]      MODE_NAND = 3'd2;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [2:0]        mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [N_IN-1:0]   fev_q, fev_d;
    logic              fevv_q, fevv_d;
    logic              exp_bit;
    logic              red_and, red_or, red_xor;

    always_comb begin
        red_and = &stim_q;
        red_or  = |stim_q;
        red_xor = ^stim_q;
        case (mode_q)
            3'd0:    exp_bit = red_and;
            3'd1:    exp_bit = red_or;
            3'd3:    exp_bit = ~red_or;
            3'd4:    exp_bit = red_xor;
            3'd5:    exp_bit = ~red_xor;
            default: exp_bit = ~red_and;  // 2, 6 and 7 all behave as NAND
        endcase
    end

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fevv_d  = fevv_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    stim_d  = '0;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fev_d   = '0;
                    fevv_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (hold_q == HOLD_LAST) begin
                    if (dut_out != exp_bit) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!fevv_q) begin
                            fevv_d = 1'b1;
                            fev_d  = stim_q;
                        end
                    end
                    if (stim_q == STIM_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        // err_d already includes the last vector's result
                        pass_d  = (err_d == '0);
                    end else begin
                        stim_d = stim_q + 1'b1;
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stim_q  <= '0;
            hold_q  <= '0;
            mode_q  <= MODE_NAND;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= '0;
            fevv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevv_q  <= fevv_d;
        end
    end

    assign stim            = stim_q;
    assign expected        = exp_bit;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fevv_q;

endmodule

// File: tb/tb_gate_exhaustive_tester.sv
// Bench for gate_exhaustive_tester: three configurations driven in lockstep, checked every cycle
// against a run-time arithmetic model plus directed literal expectations.
module tb_gate_exhaustive_tester;

    localparam int NI[3] = '{3, 3, 4};
    localparam int HC[3] = '{2, 2, 1};
    localparam int EW[3] = '{8, 2, 8};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [15:0] tt[3];

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [2:0] stim_a, fev_a;
    logic [7:0] err_a;
    logic exp_a, busy_a, done_a, pass_a, fevv_a, dout_a;
    logic [2:0] stim_b, fev_b;
    logic [1:0] err_b;
    logic exp_b, busy_b, done_b, pass_b, fevv_b, dout_b;
    logic [3:0] stim_c, fev_c;
    logic [7:0] err_c;
    logic exp_c, busy_c, done_c, pass_c, fevv_c, dout_c;

    assign dout_a = tt[0][stim_a];
    assign dout_b = tt[1][stim_b];
    assign dout_c = tt[2][stim_c];

    gate_exhaustive_tester #(.N_IN(3), .HOLD_CYCLES(2), .ERR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dut_out(dout_a),
        .stim(stim_a), .expected(exp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .first_err_vec(fev_a), .first_err_valid(fevv_a));

    gate_exhaustive_tester #(.N_IN(3), .HOLD_CYCLES(2), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dut_out(dout_b),
        .stim(stim_b), .expected(exp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .first_err_vec(fev_b), .first_err_valid(fevv_b));

    gate_exhaustive_tester #(.N_IN(4), .HOLD_CYCLES(1), .ERR_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dut_out(dout_c),
        .stim(stim_c), .expected(exp_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_cnt(err_c), .first_err_vec(fev_c), .first_err_valid(fevv_c));

    int o_stim[3], o_err[3], o_fev[3];
    int o_exp[3], o_busy[3], o_done[3], o_pass[3], o_fevv[3];

    always_comb begin
        o_stim[0] = int'(stim_a); o_err[0] = int'(err_a); o_fev[0] = int'(fev_a);
        o_exp[0] = int'(exp_a); o_busy[0] = int'(busy_a); o_done[0] = int'(done_a);
        o_pass[0] = int'(pass_a); o_fevv[0] = int'(fevv_a);
        o_stim[1] = int'(stim_b); o_err[1] = int'(err_b); o_fev[1] = int'(fev_b);
        o_exp[1] = int'(exp_b); o_busy[1] = int'(busy_b); o_done[1] = int'(done_b);
        o_pass[1] = int'(pass_b); o_fevv[1] = int'(fevv_b);
        o_stim[2] = int'(stim_c); o_err[2] = int'(err_c); o_fev[2] = int'(fev_c);
        o_exp[2] = int'(exp_c); o_busy[2] = int'(busy_c); o_done[2] = int'(done_c);
        o_pass[2] = int'(pass_c); o_fevv[2] = int'(fevv_c);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Golden gate value from the count of ones in the vector.
    function automatic int gold(input int m, input int v, input int n);
        int ones;
        int r;
        ones = $countones(v);
        case (m)
            1, 3:    r = (ones != 0) ? 1 : 0;
            4, 5:    r = ones % 2;
            default: r = (ones == n) ? 1 : 0;
        endcase
        if (m == 2 || m == 3 || m == 5 || m == 6 || m == 7) r = 1 - r;
        return r;
    endfunction

    function automatic logic [15:0] gtable(input int m, input int n);
        logic [15:0] t;
        t = '0;
        for (int v = 0; v < (1 << n); v++) t[v] = gold(m, v, n) != 0;
        return t;
    endfunction

    // Model: phase 0 idle, 1 running, 2 done; tcnt = cycles since the accepting edge.
    int ph[3], tcnt[3], ml[3];
    logic [15:0] rtt[3];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                ph[i] = 0; tcnt[i] = 0; ml[i] = 2; rtt[i] = '0;
            end else if (ph[i] == 1) begin
                tcnt[i] = tcnt[i] + 1;
                if (tcnt[i] == (1 << NI[i]) * HC[i]) ph[i] = 2;
            end else if (start) begin
                ph[i] = 1; tcnt[i] = 0; ml[i] = int'(mode); rtt[i] = tt[i];
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int nv, smp, ms, nerr, first, emax;
            nv = 1 << NI[i];
            emax = (1 << EW[i]) - 1;
            if (ph[i] == 0) begin ms = 0; smp = 0; end
            else if (ph[i] == 2) begin ms = nv - 1; smp = nv; end
            else begin ms = tcnt[i] / HC[i]; smp = ms; end
            nerr = 0; first = 0;
            for (int v = 0; v < smp; v++) begin
                if (int'(rtt[i][v]) != gold(ml[i], v, NI[i])) begin
                    if (nerr == 0) first = v;
                    nerr++;
                end
            end
            chk($sformatf("stim[%0d]", i), o_stim[i], ms);
            chk($sformatf("expected[%0d]", i), o_exp[i], gold(ml[i], ms, NI[i]));
            chk($sformatf("busy[%0d]", i), o_busy[i], (ph[i] == 1) ? 1 : 0);
            chk($sformatf("done[%0d]", i), o_done[i], (ph[i] == 2) ? 1 : 0);
            chk($sformatf("pass[%0d]", i), o_pass[i], (ph[i] == 2 && nerr == 0) ? 1 : 0);
            chk($sformatf("err_cnt[%0d]", i), o_err[i], (nerr > emax) ? emax : nerr);
            chk($sformatf("first_err_valid[%0d]", i), o_fevv[i], (nerr > 0) ? 1 : 0);
            chk($sformatf("first_err_vec[%0d]", i), o_fev[i], first);
        end
    end

    task automatic run_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Counts negedges after the start edge until done; optionally pokes start while busy.
    task automatic wait_done(input int poke, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = (poke != 0 && cyc == poke);
        end while (!(done_a && done_b && done_c) && cyc < 100);
        start = 1'b0;
        if (!(done_a && done_b && done_c)) chk("done_timeout", 0, 1);
    endtask

    task automatic set_all(input logic [15:0] t);
        for (int i = 0; i < 3; i++) tt[i] = t;
    endtask

    int cyc;

    initial begin
        set_all(16'h0);
        #12;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_stim", int'(stim_c), 0);
        @(negedge clk); rst_n = 1'b1;

        // NAND gate under NAND mode: clean sweep, done 16 cycles after the start edge
        tt[0] = gtable(2, 3); tt[1] = gtable(2, 3); tt[2] = gtable(2, 4);
        mode = 3'd2;
        run_start();
        wait_done(0, cyc);
        chk("t1_done_time", cyc, 16);
        chk("t1_pass", int'(pass_a), 1);
        chk("t1_err", int'(err_a), 0);
        chk("t1_fevv", int'(fevv_a), 0);
        chk("t1_stim_hold", int'(stim_a), 7);

        // NAND gate checked as XOR: mismatches at 0,3,5,6,7
        mode = 3'd4;
        run_start();
        wait_done(0, cyc);
        chk("t2_err", int'(err_a), 5);
        chk("t2_fev", int'(fev_a), 0);
        chk("t2_fevv", int'(fevv_a), 1);
        chk("t2_pass", int'(pass_a), 0);

        // Output tied low under NAND mode: 7 mismatches, 2-bit counter saturates
        set_all(16'h0);
        mode = 3'd2;
        run_start();
        wait_done(0, cyc);
        chk("t3_err_a", int'(err_a), 7);
        chk("t3_err_b_sat", int'(err_b), 3);
        chk("t3_fev_b", int'(fev_b), 0);
        chk("t3_pass_b", int'(pass_b), 0);

        // Start while busy is ignored; start from DONE re-runs with cleared counters
        tt[0] = gtable(2, 3); tt[1] = gtable(2, 3); tt[2] = gtable(2, 4);
        run_start();
        wait_done(4, cyc);
        chk("t4_done_time", cyc, 16);
        chk("t4_pass", int'(pass_b), 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t4_restart_done", int'(done_a), 0);
        chk("t4_restart_err", int'(err_a), 0);
        wait_done(0, cyc);
        chk("t4_rerun_pass", int'(pass_a), 1);

        // Asynchronous reset while stim=4
        set_all(16'h0);
        run_start();
        cyc = 0;
        while (stim_a != 3'd4 && cyc < 40) begin @(negedge clk); cyc++; end
        chk("t5_reach_stim4", int'(stim_a), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_stim", int'(stim_a), 0);
        chk("t5_busy", int'(busy_a), 0);
        chk("t5_err", int'(err_a), 0);
        chk("t5_fevv", int'(fevv_a), 0);
        chk("t5_fev", int'(fev_a), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_idle_done", int'(done_a), 0);
        chk("t5_idle_busy", int'(busy_a), 0);

        // Mode 6 acts as NAND; AND gate under AND mode with single-cycle hold
        tt[0] = gtable(2, 3); tt[1] = gtable(2, 3); tt[2] = gtable(2, 4);
        mode = 3'd6;
        run_start();
        wait_done(0, cyc);
        chk("t6_mode6_pass", int'(pass_a), 1);
        tt[0] = 16'h0080; tt[1] = 16'h0080; tt[2] = 16'h8000;
        mode = 3'd0;
        run_start();
        wait_done(0, cyc);
        chk("t6_c_done_time", cyc, 16);
        chk("t6_c_pass", int'(pass_c), 1);

        // Randomized runs: random mode, gate tables, busy-time starts and mid-run resets
        for (int r = 0; r < 30; r++) begin
            int kind;
            mode = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 1) == 1) tt[i] = gtable($urandom_range(0, 7), NI[i]);
                else tt[i] = 16'($urandom);
            end
            run_start();
            kind = $urandom_range(0, 4);
            if (kind == 0) begin
                repeat ($urandom_range(1, 14)) @(posedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk); rst_n = 1'b1;
            end else begin
                wait_done((kind == 1) ? $urandom_range(1, 14) : 0, cyc);
                chk("rand_done_time", cyc, 16);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
